// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, pacing and status bundle between the vending controller and the coin dispenser
interface change_dispenser_if #(parameter int AMT_W = 8, parameter int CNT_W = 4);
  logic en_tick;
  logic start;
  logic restock;
  logic [AMT_W-1:0] amount;
  logic busy;
  logic done;
  logic short_err;
  logic [AMT_W-1:0] remaining;
  logic eject_q;
  logic eject_d;
  logic eject_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_n;
  modport master (
    output en_tick, start, restock, amount,
    input  busy, done, short_err, remaining, eject_q, eject_d, eject_n, cnt_q, cnt_d, cnt_n
  );
  modport slave (
    input  en_tick, start, restock, amount,
    output busy, done, short_err, remaining, eject_q, eject_d, eject_n, cnt_q, cnt_d, cnt_n
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy quarter/dime/nickel ejection paced by en_tick, with per-coin inventory and shortfall flag
module change_dispenser #(
  parameter int AMT_W    = 8,
  parameter int CNT_W    = 4,
  parameter int MAX_COIN = 7
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PICK, ARM, DONE} state_t;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_COIN);
  state_t state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d, val;
  logic err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic [2:0] sel_q, sel_d, ej_q, ej_d;
  logic [CNT_W-1:0] cq_q, cq_d, cd_q, cd_d, cn_q, cn_d;
  // sel is one-hot {quarter, dime, nickel}; PICK guarantees rem_q >= val in ARM
  assign val = sel_q[2] ? AMT_W'(25) : sel_q[1] ? AMT_W'(10) : AMT_W'(5);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    sel_d   = sel_q;
    ej_d    = 3'b000;
    cq_d    = cq_q;
    cd_d    = cd_q;
    cn_d    = cn_q;
    case (state_q)
      IDLE: begin
        if (bus.restock) begin
          cq_d = FULL;
          cd_d = FULL;
          cn_d = FULL;
        end else if (bus.start) begin
          rem_d   = bus.amount;
          err_d   = 1'b0;
          state_d = PICK;
        end
      end
      PICK: begin
        sel_d   = (rem_q >= AMT_W'(25) && cq_q != '0) ? 3'b100 :
                  (rem_q >= AMT_W'(10) && cd_q != '0) ? 3'b010 :
                  (rem_q >= AMT_W'(5)  && cn_q != '0) ? 3'b001 : 3'b000;
        state_d = (sel_d != 3'b000) ? ARM : DONE;
        err_d   = (sel_d == 3'b000) ? (rem_q != '0) : err_q;
      end
      ARM: begin
        if (bus.en_tick) begin
          ej_d    = sel_q;
          rem_d   = rem_q - val;
          cq_d    = sel_q[2] ? cq_q - CNT_W'(1) : cq_q;
          cd_d    = sel_q[1] ? cd_q - CNT_W'(1) : cd_q;
          cn_d    = sel_q[0] ? cn_q - CNT_W'(1) : cn_q;
          state_d = PICK;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
      sel_q   <= 3'b000;
      ej_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cq_q    <= FULL;
      cd_q    <= FULL;
      cn_q    <= FULL;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      ej_q    <= ej_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cq_q    <= cq_d;
      cd_q    <= cd_d;
      cn_q    <= cn_d;
    end
  end
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.short_err = err_q;
  assign bus.remaining = rem_q;
  assign bus.eject_q   = ej_q[2];
  assign bus.eject_d   = ej_q[1];
  assign bus.eject_n   = ej_q[0];
  assign bus.cnt_q     = cq_q;
  assign bus.cnt_d     = cd_q;
  assign bus.cnt_n     = cn_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench; a greedy model queues expected ejects and completions, a monitor pops and compares
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  change_dispenser_if #(.AMT_W(8), .CNT_W(4)) bus ();
  change_dispenser #(.AMT_W(8), .CNT_W(4), .MAX_COIN(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] rem;
    logic [3:0] q;
    logic [3:0] d;
    logic [3:0] n;
  } done_t;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  logic [2:0] coin_fifo[$];
  logic [7:0] rem_fifo[$];
  done_t done_fifo[$];
  int mq = 7, md = 7, mn = 7;

  initial begin
    bus.en_tick = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      bus.en_tick = 1'b1;
      @(negedge clk);
      bus.en_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [2:0] ej, ec;
    logic [7:0] er;
    done_t dr;
    ej = {bus.eject_q, bus.eject_d, bus.eject_n};
    if (!rst && ej != 3'b000) begin
      total++;
      if (coin_fifo.size() == 0) $display("FAIL unexpected_eject got=%b want=none", ej);
      else begin
        ec = coin_fifo.pop_front();
        er = rem_fifo.pop_front();
        if (ej !== ec || bus.remaining !== er)
          $display("FAIL eject got=%b rem=%0d want=%b rem=%0d", ej, bus.remaining, ec, er);
        else passed++;
      end
    end
    if (!rst && bus.done) begin
      done_cnt++;
      total++;
      if (done_fifo.size() == 0) $display("FAIL unexpected_done got=1 want=0");
      else begin
        dr = done_fifo.pop_front();
        if (bus.short_err !== dr.err || bus.remaining !== dr.rem || bus.cnt_q !== dr.q ||
            bus.cnt_d !== dr.d || bus.cnt_n !== dr.n || bus.busy !== 1'b1)
          $display("FAIL done got err=%b rem=%0d cnt=%0d/%0d/%0d busy=%b want err=%b rem=%0d cnt=%0d/%0d/%0d busy=1",
                   bus.short_err, bus.remaining, bus.cnt_q, bus.cnt_d, bus.cnt_n, bus.busy,
                   dr.err, dr.rem, dr.q, dr.d, dr.n);
        else passed++;
      end
    end
  end

  task automatic predict(input int amt);
    int r = amt;
    done_t dr;
    forever begin
      if (r >= 25 && mq > 0) begin mq--; r -= 25; coin_fifo.push_back(3'b100); end
      else if (r >= 10 && md > 0) begin md--; r -= 10; coin_fifo.push_back(3'b010); end
      else if (r >= 5 && mn > 0) begin mn--; r -= 5; coin_fifo.push_back(3'b001); end
      else break;
      rem_fifo.push_back(8'(r));
    end
    dr.err = (r != 0);
    dr.rem = 8'(r);
    dr.q = 4'(mq);
    dr.d = 4'(md);
    dr.n = 4'(mn);
    done_fifo.push_back(dr);
  endtask

  task automatic issue(input int amt);
    predict(amt);
    bus.amount = 8'(amt);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int target = done_cnt + 1;
    int k = 0;
    while (done_cnt < target && k < 3000) begin @(negedge clk); k++; end
    if (done_cnt < target) begin
      total++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
    @(negedge clk);
  endtask

  task automatic do_restock();
    bus.restock = 1'b1;
    @(negedge clk);
    bus.restock = 1'b0;
    mq = 7; md = 7; mn = 7;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({bus.cnt_q, bus.cnt_d, bus.cnt_n} !== {4'd7, 4'd7, 4'd7} || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.short_err !== 1'b0 || {bus.eject_q, bus.eject_d, bus.eject_n} !== 3'b000 || bus.remaining !== 8'd0)
      $display("FAIL reset got cnt=%0d/%0d/%0d busy=%b done=%b err=%b rem=%0d want 7/7/7 0 0 0 0",
               bus.cnt_q, bus.cnt_d, bus.cnt_n, bus.busy, bus.done, bus.short_err, bus.remaining);
    else passed++;
  endtask

  task automatic test_basic();
    issue(40);
    wait_done("basic");
    total++;
    if (bus.busy !== 1'b0 || bus.short_err !== 1'b0 || bus.remaining !== 8'd0)
      $display("FAIL basic_idle got busy=%b err=%b rem=%0d want 0 0 0", bus.busy, bus.short_err, bus.remaining);
    else passed++;
  endtask

  task automatic test_shortage();
    do_restock();
    issue(175);
    wait_done("drain_q");
    issue(60);
    wait_done("drain_d");
    for (int i = 0; i < 6; i++) begin
      issue(5);
      wait_done("drain_n");
    end
    total++;
    if ({bus.cnt_q, bus.cnt_d, bus.cnt_n} !== {4'd0, 4'd1, 4'd1})
      $display("FAIL drain_cnt got=%0d/%0d/%0d want=0/1/1", bus.cnt_q, bus.cnt_d, bus.cnt_n);
    else passed++;
    issue(30);
    wait_done("shortage");
    repeat (3) @(negedge clk);
    total++;
    if (bus.short_err !== 1'b1 || bus.remaining !== 8'd15)
      $display("FAIL short_hold got err=%b rem=%0d want err=1 rem=15", bus.short_err, bus.remaining);
    else passed++;
  endtask

  task automatic test_zero_and_odd();
    do_restock();
    predict(0);
    bus.amount = 8'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL zero_t1 got busy=%b done=%b want 1 0", bus.busy, bus.done);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1) $display("FAIL zero_t2 got done=%b want 1", bus.done);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL zero_t3 got busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
    issue(7);
    wait_done("odd");
    total++;
    if (bus.short_err !== 1'b1 || bus.remaining !== 8'd2)
      $display("FAIL odd got err=%b rem=%0d want err=1 rem=2", bus.short_err, bus.remaining);
    else passed++;
    issue(3);
    wait_done("sub_nickel");
  endtask

  task automatic test_busy_ignore();
    do_restock();
    issue(40);
    repeat (3) @(negedge clk);
    bus.amount = 8'd100;
    bus.start = 1'b1;
    bus.restock = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.restock = 1'b0;
    wait_done("busy_ignore");
    do_restock();
    total++;
    if ({bus.cnt_q, bus.cnt_d, bus.cnt_n} !== {4'd7, 4'd7, 4'd7})
      $display("FAIL restock got=%0d/%0d/%0d want=7/7/7", bus.cnt_q, bus.cnt_d, bus.cnt_n);
    else passed++;
    predict(0);
    bus.amount = 8'd0;
    bus.start = 1'b1;
    bus.restock = 1'b1;
    @(negedge clk);
    void'(done_fifo.pop_back());
    bus.start = 1'b0;
    bus.restock = 1'b0;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL restock_wins got busy=%b want 0", bus.busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    issue(40);
    while (bus.eject_q !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    total++;
    if (bus.eject_q !== 1'b1) $display("FAIL mid_first_eject got=0 want=1");
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    coin_fifo.delete();
    rem_fifo.delete();
    done_fifo.delete();
    mq = 7; md = 7; mn = 7;
    total++;
    if (bus.busy !== 1'b0 || bus.remaining !== 8'd0 || {bus.cnt_q, bus.cnt_d, bus.cnt_n} !== {4'd7, 4'd7, 4'd7} ||
        {bus.eject_q, bus.eject_d, bus.eject_n} !== 3'b000)
      $display("FAIL mid_reset got busy=%b rem=%0d cnt=%0d/%0d/%0d want 0 0 7/7/7",
               bus.busy, bus.remaining, bus.cnt_q, bus.cnt_d, bus.cnt_n);
    else passed++;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(85);
    wait_done("b2b_a");
    issue(45);
    wait_done("b2b_b");
    total++;
    if (coin_fifo.size() != 0 || done_fifo.size() != 0)
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", coin_fifo.size(), done_fifo.size());
    else passed++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.restock = 1'b0;
    bus.amount = 8'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_shortage();
    test_zero_and_odd();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
